gray_host: RTL and testbench

GRAY_HOST -- requirements
Module: gray_host

---
 rtl/gray_host_if.sv | 35 +++
 rtl/gray_host.sv | 99 +++++++++
 tb/tb_gray_host.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gray_host_if.sv
// Host-side bus of the gray image host: image load stream, engine read/write
// ports and result readback.
interface gray_host_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W:0]   lbp_cnt;
  logic              done;

  modport master (
    output start, load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_addr,
    input  load_ready, gray_ready, gray_data, res_data, lbp_cnt, done
  );

  modport slave (
    input  start, load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_addr,
    output load_ready, gray_ready, gray_data, res_data, lbp_cnt, done
  );
endinterface

// File: rtl/gray_host.sv
// Gray image host: loads an image in raster order, serves pixel reads to an
// engine, captures its result writes and exposes them for readback.
module gray_host #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int NPIX   = 16384
) (
  input  logic        clk,
  input  logic        reset,
  gray_host_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              load_ready_q, gray_ready_q, done_q;
  logic [DATA_W-1:0] gray_data_q, res_data_q;
  logic              img_we, res_we, rd_en;

  logic [DATA_W-1:0] img_mem [NPIX];
  logic [DATA_W-1:0] res_mem [NPIX];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    img_we  = 1'b0;
    res_we  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          img_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (ptr_q == LAST) state_d = SERVE;
        end
      end
      SERVE: begin
        // finish on the same edge still lets that edge's read/write through
        rd_en = bus.gray_req;
        if (bus.lbp_valid) begin
          res_we = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (bus.finish) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memories carry no reset so image/result contents survive an abort
  always_ff @(posedge clk) begin
    if (img_we) img_mem[ptr_q] <= bus.load_data;
    if (res_we) res_mem[bus.lbp_addr] <= bus.lbp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      gray_data_q  <= '0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      load_ready_q <= (state_d == LOAD);
      gray_ready_q <= (state_d == SERVE);
      done_q       <= (state_d == DONE);
      if (rd_en) gray_data_q <= img_mem[bus.gray_addr];
      res_data_q   <= res_mem[bus.res_addr];
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.gray_ready = gray_ready_q;
  assign bus.done       = done_q;
  assign bus.gray_data  = gray_data_q;
  assign bus.res_data   = res_data_q;
  assign bus.lbp_cnt    = cnt_q;
endmodule

// File: tb/tb_gray_host.sv
// Directed bench for gray_host: load, serve, result capture, finish, abort and
// gapped reload.
module tb_gray_host;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int NPIX   = 16384;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   idx;

  gray_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  gray_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.gray_req   = 1'b0;
    bus.gray_addr  = '0;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.res_addr   = '0;
    #2;
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_gray_data",  32'(bus.gray_data),  32'd0);
    check("rst_res_data",   32'(bus.res_data),   32'd0);
    check("rst_lbp_cnt",    32'(bus.lbp_cnt),    32'd0);
    tick();
    reset = 1'b0;
    bus.load_valid = 1'b1;   // ignored in IDLE
    tick();
    check("idle_load_ready", 32'(bus.load_ready), 32'd0);

    // Full contiguous load, pixel = addr[7:0]
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("load_ready_up", 32'(bus.load_ready), 32'd1);
    for (int i = 0; i < NPIX - 1; i++) begin
      bus.load_data = 8'(i);
      tick();
    end
    check("pre_last_load_ready", 32'(bus.load_ready), 32'd1);
    check("pre_last_gray_ready", 32'(bus.gray_ready), 32'd0);
    bus.load_data = 8'hFF;
    tick();
    bus.load_valid = 1'b0;
    check("post_last_load_ready", 32'(bus.load_ready), 32'd0);
    check("post_last_gray_ready", 32'(bus.gray_ready), 32'd1);

    // Back-to-back reads
    bus.gray_req = 1'b1;
    bus.gray_addr = 14'd0;     tick(); check("rd_0",     32'(bus.gray_data), 32'h00);
    bus.gray_addr = 14'd129;   tick(); check("rd_129",   32'(bus.gray_data), 32'h81);
    bus.gray_addr = 14'd16383; tick(); check("rd_16383", 32'(bus.gray_data), 32'hFF);
    bus.gray_req = 1'b0;
    bus.gray_addr = 14'd50;    tick(); check("rd_hold",  32'(bus.gray_data), 32'hFF);

    // Result writes with overwrite
    bus.lbp_valid = 1'b1;
    bus.lbp_addr = 14'd5; bus.lbp_data = 8'h3C; tick();
    bus.lbp_addr = 14'd5; bus.lbp_data = 8'hA7; tick();
    bus.lbp_valid = 1'b0;
    check("lbp_cnt_2", 32'(bus.lbp_cnt), 32'd2);
    check("serve_done", 32'(bus.done), 32'd0);

    // finish with concurrent read and write
    bus.finish = 1'b1;
    bus.gray_req = 1'b1; bus.gray_addr = 14'd2;
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd7; bus.lbp_data = 8'h11;
    tick();
    bus.finish = 1'b0; bus.gray_req = 1'b0; bus.lbp_valid = 1'b0;
    check("fin_gray_data",  32'(bus.gray_data),  32'h02);
    check("fin_done",       32'(bus.done),       32'd1);
    check("fin_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("fin_lbp_cnt",    32'(bus.lbp_cnt),    32'd3);
    bus.res_addr = 14'd5; tick(); check("res_5", 32'(bus.res_data), 32'hA7);
    bus.res_addr = 14'd7; tick(); check("res_7", 32'(bus.res_data), 32'h11);

    // DONE ignores engine traffic and load data
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd7; bus.lbp_data = 8'h55;
    bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
    bus.load_valid = 1'b1;
    tick();
    bus.lbp_valid = 1'b0; bus.gray_req = 1'b0; bus.load_valid = 1'b0;
    tick();
    check("done_lbp_cnt",   32'(bus.lbp_cnt),   32'd3);
    check("done_gray_hold", 32'(bus.gray_data), 32'h02);
    check("done_res_7",     32'(bus.res_data),  32'h11);
    check("done_stays",     32'(bus.done),      32'd1);

    // Restart from DONE, abort after 100 pixels
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_cnt",   32'(bus.lbp_cnt),    32'd0);
    check("restart_load",  32'(bus.load_ready), 32'd1);
    check("restart_done",  32'(bus.done),       32'd0);
    bus.load_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.load_data = ~8'(i);
      tick();
    end
    bus.load_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_load_ready", 32'(bus.load_ready), 32'd0);
    check("abort_gray_data",  32'(bus.gray_data),  32'd0);
    check("abort_res_data",   32'(bus.res_data),   32'd0);
    check("abort_done",       32'(bus.done),       32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Reload with load_valid toggling every cycle, pixel = addr[7:0] ^ 0x5A
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    idx = 0;
    for (int c = 1; c < 2 * NPIX - 1; c++) begin
      bus.load_valid = c[0];
      if (c[0]) begin
        bus.load_data = 8'(idx) ^ 8'h5A;
        idx++;
      end
      tick();
    end
    check("gap_pre_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("gap_pre_load_ready", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data = 8'(idx) ^ 8'h5A;
    tick();
    bus.load_valid = 1'b0;
    check("gap_gray_ready", 32'(bus.gray_ready), 32'd1);
    check("gap_load_ready", 32'(bus.load_ready), 32'd0);
    bus.gray_req = 1'b1;
    bus.gray_addr = 14'd0;     tick(); check("gap_rd_0",     32'(bus.gray_data), 32'h5A);
    bus.gray_addr = 14'd129;   tick(); check("gap_rd_129",   32'(bus.gray_data), 32'hDB);
    bus.gray_addr = 14'd16383; tick(); check("gap_rd_16383", 32'(bus.gray_data), 32'hA5);
    bus.gray_req = 1'b0;
    bus.res_addr = 14'd7; tick(); check("res_kept_7", 32'(bus.res_data), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
